// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: periodic multi-channel scan controller for the
// adc128s022 SPI controller in the uart_scope datapath.
//
// Ports:
//   clk, rst                 system clock, asynchronous active-low reset
//   scan_en, ch_mask         scan enable level and per-channel enable mask
//   sample_period            scan period in clk cycles (0 = back-to-back scans)
//   adc_en_conv/adc_channel  start pulse and channel select to the controller
//   adc_state/adc_conv_done  controller idle flag and completion pulse
//   adc_data                 conversion result, valid with adc_conv_done
//   smp_valid/smp_ready      one-entry output register handshake
//   smp_channel/smp_data     tagged sample held in the output register
//   busy                     a scan is in progress
//   overrun_cnt/timeout_cnt  saturating event counters
module adc_scan_sequencer #(
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned TIMEOUT  = 4096,
  parameter int unsigned OVR_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scan_en,
  input  logic [7:0]          ch_mask,
  input  logic [PERIOD_W-1:0] sample_period,
  output logic                adc_en_conv,
  output logic [2:0]          adc_channel,
  input  logic                adc_state,
  input  logic                adc_conv_done,
  input  logic [11:0]         adc_data,
  output logic                smp_valid,
  input  logic                smp_ready,
  output logic [2:0]          smp_channel,
  output logic [11:0]         smp_data,
  output logic                busy,
  output logic [OVR_W-1:0]    overrun_cnt,
  output logic [OVR_W-1:0]    timeout_cnt
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_PICK,
    S_START,
    S_WAIT_DONE,
    S_PUSH
  } state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] tcnt_q, tcnt_d;
  logic                tick_q, tick_d;
  logic [7:0]          mask_q, mask_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [2:0]          cur_ch_q, cur_ch_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [11:0]         res_q, res_d;
  logic                adc_en_conv_q, adc_en_conv_d;
  logic [2:0]          adc_channel_q, adc_channel_d;
  logic                smp_valid_q, smp_valid_d;
  logic [2:0]          smp_channel_q, smp_channel_d;
  logic [11:0]         smp_data_q, smp_data_d;
  logic                busy_q, busy_d;
  logic [OVR_W-1:0]    overrun_q, overrun_d;
  logic [OVR_W-1:0]    timeout_q, timeout_d;

  logic                idle_like_c;
  logic [PERIOD_W-1:0] eff_period_c;
  logic [2:0]          low_ch_c;

  assign idle_like_c = (state_q == S_IDLE) || (state_q == S_WAIT_TICK);

  // While a scan runs the timer follows the period latched at scan start,
  // so a mid-scan period change only applies from the next scan.
  assign eff_period_c = idle_like_c ? sample_period : period_q;

  // Tick timer; >= recovers cleanly if the period shrinks below tcnt.
  always_comb begin
    tcnt_d = '0;
    tick_d = 1'b0;
    if (scan_en && (eff_period_c != '0)) begin
      if (tcnt_q >= eff_period_c - PERIOD_W'(1)) begin
        tick_d = 1'b1;
      end else begin
        tcnt_d = tcnt_q + PERIOD_W'(1);
      end
    end
  end

  // Lowest set bit of the remaining scan mask.
  always_comb begin
    low_ch_c = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) low_ch_c = 3'(i);
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    period_d      = period_q;
    cur_ch_d      = cur_ch_q;
    to_cnt_d      = to_cnt_q;
    res_d         = res_q;
    adc_en_conv_d = 1'b0;
    adc_channel_d = adc_channel_q;
    smp_valid_d   = smp_valid_q & ~smp_ready;
    smp_channel_d = smp_channel_q;
    smp_data_d    = smp_data_q;
    overrun_d     = overrun_q;
    timeout_d     = timeout_q;

    // Ticks landing mid-scan are dropped and counted.
    if (tick_q && !idle_like_c && (overrun_q != '1)) begin
      overrun_d = overrun_q + OVR_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (scan_en) state_d = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        if (!scan_en) begin
          state_d = S_IDLE;
        end else if (tick_q || (sample_period == '0)) begin
          mask_d   = ch_mask;
          period_d = sample_period;
          if (ch_mask != 8'd0) state_d = S_PICK;
        end
      end
      S_PICK: begin
        if (mask_q == 8'd0) begin
          state_d = scan_en ? S_WAIT_TICK : S_IDLE;
        end else begin
          cur_ch_d = low_ch_c;
          mask_d   = mask_q & (mask_q - 8'd1);
          state_d  = S_START;
        end
      end
      S_START: begin
        if (adc_state) begin
          adc_channel_d = cur_ch_q;
          adc_en_conv_d = 1'b1;
          to_cnt_d      = TO_W'(TIMEOUT);
          state_d       = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (adc_conv_done) begin
          res_d   = adc_data;
          state_d = S_PUSH;
        end else if (to_cnt_q <= TO_W'(1)) begin
          if (timeout_q != '1) timeout_d = timeout_q + OVR_W'(1);
          state_d = S_PICK;
        end else begin
          to_cnt_d = to_cnt_q - TO_W'(1);
        end
      end
      S_PUSH: begin
        if (!smp_valid_q || smp_ready) begin
          smp_valid_d   = 1'b1;
          smp_channel_d = cur_ch_q;
          smp_data_d    = res_q;
          state_d       = S_PICK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = !((state_d == S_IDLE) || (state_d == S_WAIT_TICK));

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      tcnt_q        <= '0;
      tick_q        <= 1'b0;
      mask_q        <= '0;
      period_q      <= '0;
      cur_ch_q      <= '0;
      to_cnt_q      <= '0;
      res_q         <= '0;
      adc_en_conv_q <= 1'b0;
      adc_channel_q <= '0;
      smp_valid_q   <= 1'b0;
      smp_channel_q <= '0;
      smp_data_q    <= '0;
      busy_q        <= 1'b0;
      overrun_q     <= '0;
      timeout_q     <= '0;
    end else begin
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      tick_q        <= tick_d;
      mask_q        <= mask_d;
      period_q      <= period_d;
      cur_ch_q      <= cur_ch_d;
      to_cnt_q      <= to_cnt_d;
      res_q         <= res_d;
      adc_en_conv_q <= adc_en_conv_d;
      adc_channel_q <= adc_channel_d;
      smp_valid_q   <= smp_valid_d;
      smp_channel_q <= smp_channel_d;
      smp_data_q    <= smp_data_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  assign adc_en_conv = adc_en_conv_q;
  assign adc_channel = adc_channel_q;
  assign smp_valid   = smp_valid_q;
  assign smp_channel = smp_channel_q;
  assign smp_data    = smp_data_q;
  assign busy        = busy_q;
  assign overrun_cnt = overrun_q;
  assign timeout_cnt = timeout_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Testbench for adc_scan_sequencer: behavioural adc128s022 controller model,
// scoreboard of expected tagged samples, directed scenarios.
module tb_adc_scan_sequencer;

  localparam int unsigned PERIOD_W = 24;
  localparam int unsigned OVR_W    = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                scan_en;
  logic [7:0]          ch_mask;
  logic [PERIOD_W-1:0] sample_period;
  logic                adc_en_conv;
  logic [2:0]          adc_channel;
  logic                adc_state;
  logic                adc_conv_done;
  logic [11:0]         adc_data;
  logic                smp_valid;
  logic                smp_ready;
  logic [2:0]          smp_channel;
  logic [11:0]         smp_data;
  logic                busy;
  logic [OVR_W-1:0]    overrun_cnt;
  logic [OVR_W-1:0]    timeout_cnt;

  adc_scan_sequencer #(.PERIOD_W(PERIOD_W), .TIMEOUT(4096), .OVR_W(OVR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .scan_en       (scan_en),
    .ch_mask       (ch_mask),
    .sample_period (sample_period),
    .adc_en_conv   (adc_en_conv),
    .adc_channel   (adc_channel),
    .adc_state     (adc_state),
    .adc_conv_done (adc_conv_done),
    .adc_data      (adc_data),
    .smp_valid     (smp_valid),
    .smp_ready     (smp_ready),
    .smp_channel   (smp_channel),
    .smp_data      (smp_data),
    .busy          (busy),
    .overrun_cnt   (overrun_cnt),
    .timeout_cnt   (timeout_cnt)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] data;
  } smp_t;

  smp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   en_pulses = 0;
  bit   busy_seen = 1'b0;
  int   model_lat = 20;
  bit   model_hang = 1'b0;
  int   t[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] conv_val(input logic [2:0] ch);
    case (ch)
      3'd0:    return 12'hABC;
      3'd5:    return 12'h123;
      default: return 12'h800 + 12'(ch) * 12'h011;
    endcase
  endfunction

  // Controller model: accepts a start pulse, converts for model_lat cycles.
  initial begin : adc_model
    logic [2:0] ch;
    adc_state     = 1'b1;
    adc_conv_done = 1'b0;
    adc_data      = 12'hFFF;
    forever begin
      @(posedge clk); #1;
      if (adc_en_conv && !model_hang) begin
        ch        = adc_channel;
        adc_state = 1'b0;
        repeat (model_lat) @(posedge clk);
        #1;
        adc_conv_done = 1'b1;
        adc_data      = conv_val(ch);
        @(posedge clk); #1;
        adc_conv_done = 1'b0;
        adc_data      = 12'hFFF;
        adc_state     = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin : mon
    smp_t e;
    if (adc_en_conv) en_pulses++;
    if (busy) busy_seen = 1'b1;
    if (rst && smp_valid && smp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sample_unexpected: got ch=%0d data=%0h expected none", smp_channel, smp_data);
      end else begin
        e = exp_q.pop_front();
        check("sample", {17'd0, smp_channel, smp_data}, {17'd0, e});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    scan_en = 1'b0;
    rst = 1'b0;
    cycles(3);
    rst = 1'b1;
    cycles(1);
  endtask

  task automatic drain(input string name, input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      cycles(1);
      k++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin : main
    int n, en0;
    rst = 1'b0; scan_en = 1'b0; ch_mask = 8'h00; sample_period = '0; smp_ready = 1'b1;
    cycles(3);
    check("rst_en_conv", adc_en_conv, 0);
    check("rst_channel", adc_channel, 0);
    check("rst_smp", {smp_valid, smp_channel, smp_data}, 0);
    check("rst_busy", busy, 0);
    check("rst_cnts", {overrun_cnt, timeout_cnt}, 0);
    rst = 1'b1;
    cycles(1);

    // Two-channel periodic scan: latency and period
    ch_mask = 8'h21; sample_period = 1000; model_lat = 20;
    exp_q.push_back({3'd0, 12'hABC}); exp_q.push_back({3'd5, 12'h123});
    exp_q.push_back({3'd0, 12'hABC}); exp_q.push_back({3'd5, 12'h123});
    scan_en = 1'b1;
    n = 0;
    for (int c = 1; c <= 2100; c++) begin
      cycles(1);
      if (adc_en_conv && n < 4) begin
        t[n] = c;
        n++;
      end
    end
    check("t1_pulses", n, 4);
    check("t1_first_conv", t[0], 1003);
    check("t1_ch5_conv", t[1], 1027);
    check("t1_scan2_conv", t[2], 2003);
    check("t1_scan2_ch5", t[3], 2027);
    drain("t1_drain", 100);
    check("t1_overrun", overrun_cnt, 0);
    scan_en = 1'b0;
    cycles(5);
    check("t1_busy_off", busy, 0);

    // Eight channels, slow conversions, overruns
    do_reset();
    ch_mask = 8'hFF; sample_period = 50; model_lat = 230;
    exp_q.push_back({3'd0, 12'hABC}); exp_q.push_back({3'd1, 12'h811});
    exp_q.push_back({3'd2, 12'h822}); exp_q.push_back({3'd3, 12'h833});
    exp_q.push_back({3'd4, 12'h844}); exp_q.push_back({3'd5, 12'h123});
    exp_q.push_back({3'd6, 12'h866}); exp_q.push_back({3'd7, 12'h877});
    en0 = en_pulses;
    scan_en = 1'b1;
    cycles(1940);
    check("t2_overrun", overrun_cnt, 37);
    check("t2_busy", busy, 0);
    check("t2_convs", en_pulses - en0, 8);
    drain("t2_drain", 0);
    scan_en = 1'b0;
    cycles(5);

    // Backpressure
    do_reset();
    ch_mask = 8'h03; sample_period = 100; model_lat = 20; smp_ready = 1'b0;
    exp_q.push_back({3'd0, 12'hABC}); exp_q.push_back({3'd1, 12'h811});
    scan_en = 1'b1;
    cycles(2000);
    check("t3_hold_valid", smp_valid, 1);
    check("t3_hold_sample", {smp_channel, smp_data}, {3'd0, 12'hABC});
    check("t3_hold_busy", busy, 1);
    cycles(2950);
    scan_en = 1'b0;
    cycles(50);
    check("t3_hold_late", {smp_valid, smp_channel, smp_data}, {1'b1, 3'd0, 12'hABC});
    smp_ready = 1'b1;
    cycles(1);
    check("t3_next_sample", {smp_valid, smp_channel, smp_data}, {1'b1, 3'd1, 12'h811});
    cycles(9);
    check("t3_overrun", overrun_cnt, 48);
    check("t3_idle", {busy, smp_valid}, 0);
    drain("t3_drain", 0);

    // Conversion timeout in continuous mode
    do_reset();
    model_hang = 1'b1; ch_mask = 8'h01; sample_period = 0;
    scan_en = 1'b1;
    cycles(4099);
    check("t4_to_before", timeout_cnt, 0);
    cycles(1);
    check("t4_to_first", timeout_cnt, 1);
    cycles(4100);
    check("t4_to_second", timeout_cnt, 2);
    check("t4_no_sample", smp_valid, 0);
    check("t4_overrun", overrun_cnt, 0);
    model_hang = 1'b0;
    do_reset();

    // Empty mask
    ch_mask = 8'h00; sample_period = 10;
    en0 = en_pulses;
    busy_seen = 1'b0;
    scan_en = 1'b1;
    cycles(200);
    check("t5_no_conv", en_pulses - en0, 0);
    check("t5_overrun", overrun_cnt, 0);
    check("t5_busy_seen", busy_seen, 0);
    scan_en = 1'b0;
    cycles(2);

    // Reset during WAIT_DONE
    do_reset();
    ch_mask = 8'h01; sample_period = 100; model_lat = 500;
    scan_en = 1'b1;
    cycles(200);
    check("t6_busy_pre", busy, 1);
    rst = 1'b0;
    #1;
    check("t6_rst_outs", {busy, smp_valid, adc_en_conv, adc_channel}, 0);
    check("t6_rst_cnts", {overrun_cnt, timeout_cnt}, 0);
    cycles(500);
    exp_q.push_back({3'd0, 12'hABC});
    rst = 1'b1;
    n = 0;
    for (int c = 1; c <= 200 && n == 0; c++) begin
      cycles(1);
      if (adc_en_conv) n = c;
    end
    check("t6_restart_conv", n, 103);
    drain("t6_drain", 700);
    check("t6_overrun", overrun_cnt, 5);
    scan_en = 1'b0;
    cycles(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Sequences the adc128s022 SPI controller for the uart_scope datapath.
- A programmable sample timer fires periodic scans. Each scan converts every enabled channel once, in ascending channel order.
- Each 12-bit result is tagged with its channel number and handed downstream (UART framer) through a one-entry valid/ready output register.
- Counts scan overruns and conversion timeouts.

Parameters:
- PERIOD_W, 24, width of the sample_period input and the tick counter.
- TIMEOUT, 4096, clk cycles allowed between adc_en_conv and adc_conv_done before abort.
- OVR_W, 16, width of the saturating overrun and timeout counters.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous active-low reset
- scan_en  in  1  level; 1 enables periodic scanning
- ch_mask  in  8  channel enable mask; bit n enables channel n
- sample_period  in  PERIOD_W  scan period in clk cycles; 0 = continuous mode
- adc_en_conv  out  1  one-cycle start pulse to the adc128s022 controller
- adc_channel  out  3  channel select to the controller
- adc_state  in  1  controller status; 1 = idle, 0 = converting
- adc_conv_done  in  1  one-cycle pulse; adc_data is valid in the same cycle
- adc_data  in  12  conversion result
- smp_valid  out  1  output sample valid
- smp_ready  in  1  downstream accept
- smp_channel  out  3  channel of the held sample
- smp_data  out  12  held sample
- busy  out  1  scan in progress (state not IDLE or WAIT_TICK)
- overrun_cnt  out  OVR_W  ticks lost because a scan was still running; saturating
- timeout_cnt  out  OVR_W  aborted conversions; saturating

Behaviour:
- Reset (rst low, async) clears all outputs, counters and the tick counter to 0 and sets the FSM to IDLE.
- Tick timer:
  - tcnt is held at 0 while scan_en = 0.
  - Otherwise tcnt increments; when tcnt == sample_period-1, tick is high for 1 cycle and tcnt returns to 0.
  - First tick arrives sample_period cycles after scan_en rises.
  - sample_period == 1 gives a tick every cycle.
  - sample_period == 0: no ticks; the FSM starts a new scan immediately after each scan completes.
- FSM states:
  - IDLE: go to WAIT_TICK when scan_en = 1.
  - WAIT_TICK:
    - On tick (or immediately in continuous mode): latch ch_mask into mask_r and sample_period into the active period, then go to PICK.
    - If the latched mask is 0, stay in WAIT_TICK; no conversion and no overrun.
    - If scan_en = 0, go to IDLE.
  - PICK: select the lowest set bit of mask_r as cur_ch and clear that bit. If mask_r is already 0, the scan is complete: go to WAIT_TICK, or to IDLE if scan_en = 0.
  - START: wait for adc_state = 1. Then drive adc_channel = cur_ch, pulse adc_en_conv for exactly 1 cycle, load the timeout counter, and go to WAIT_DONE.
  - WAIT_DONE:
    - adc_channel is held stable.
    - On adc_conv_done, capture adc_data and go to PUSH.
    - If TIMEOUT cycles elapse without done, increment timeout_cnt, discard the result, and go to PICK.
  - PUSH:
    - If smp_valid = 0, or smp_valid & smp_ready this cycle, load smp_data/smp_channel, set smp_valid, and go to PICK.
    - Otherwise stall in PUSH (backpressure).
- Output register: smp_valid clears on smp_valid & smp_ready unless it is reloaded in the same cycle. Data is stable while valid & !ready.
- Overrun: a tick arriving in any state other than IDLE/WAIT_TICK increments overrun_cnt. That tick is dropped and does not queue.
- Latency: adc_en_conv rises 3 cycles after tick (WAIT_TICK→PICK→START, pulse issued in START) when the controller is idle. smp_valid rises 2 cycles after adc_conv_done when the output register is empty.
- scan_en falling mid-scan: finish the current scan, including pending pushes, then go to IDLE. The tick timer stops immediately.
- ch_mask or sample_period change mid-scan: takes effect at the next scan.
- Counters saturate at all-ones and do not wrap.

Test Plan:
- rst low, then high; ch_mask = 8'h21, sample_period = 1000, smp_ready = 1, model returns 12'hABC for ch0 and 12'h123 for ch5.
  → first adc_en_conv 1003 cycles after scan_en rises; samples (0, ABC) then (5, 123); repeats every 1000 cycles; overrun_cnt = 0.
- ch_mask = 8'hFF, sample_period = 50, model conversion takes ~230 cycles (div_parm 13).
  → channels 0..7 in order; overrun_cnt increments once per dropped tick; no conversion is skipped.
- smp_ready held 0 for 5000 cycles, ch_mask = 8'h03.
  → smp_valid stays 1 with the ch0 sample stable; FSM stalls in PUSH; on release, the ch1 sample follows 1 cycle after the handshake.
- Model never asserts adc_conv_done, ch_mask = 8'h01, sample_period = 0.
  → timeout_cnt increments every ~4096 cycles; smp_valid stays 0.
- ch_mask = 0, sample_period = 10 for 200 cycles.
  → no adc_en_conv pulses, overrun_cnt = 0; busy stays 0.
- rst pulsed low during WAIT_DONE.
  → all outputs 0 immediately; after release, scanning restarts cleanly from the first tick.
